// File: rtl/fpu_mul_arbiter_if.sv
// Requester-side bus of the shared mantissa multiplier: two request ports,
// the per-port result strobes with the shared result data/tag, and busy.
interface fpu_mul_arbiter_if #(
  parameter int OP_W  = 24,
  parameter int TAG_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_a;
  logic [OP_W-1:0]   req0_b;
  logic [TAG_W-1:0]  req0_tag;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_a;
  logic [OP_W-1:0]   req1_b;
  logic [TAG_W-1:0]  req1_tag;

  logic              res0_valid;
  logic              res1_valid;
  logic [2*OP_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    input  req0_ready, req1_ready,
    input  res0_valid, res1_valid, res_data, res_tag, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    output req0_ready, req1_ready,
    output res0_valid, res1_valid, res_data, res_tag, busy
  );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// Round-robin front end for the shared pipelined mantissa multiplier; a tag
// pipeline matched to the multiplier latency routes each product back home.
module fpu_mul_arbiter #(
  parameter int MUL_LAT = 3,
  parameter int OP_W    = 24,
  parameter int TAG_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  fpu_mul_arbiter_if.slave    bus,
  output logic [OP_W-1:0]     mul_a,
  output logic [OP_W-1:0]     mul_b,
  input  logic [2*OP_W-1:0]   mul_product
);

  logic prio_reg;
  logic prio_next;
  logic grant0;
  logic grant1;
  logic xfer;
  logic [MUL_LAT:0] stage_valid;
  logic res0_valid_reg;
  logic res1_valid_reg;
  logic [2*OP_W-1:0] res_data_reg;
  logic [TAG_W-1:0]  res_tag_reg;

  // Grants depend only on the valids and the priority pointer, never on ready.
  always_comb begin
    grant0    = bus.req0_valid && (!bus.req1_valid || !prio_reg);
    grant1    = bus.req1_valid && (!bus.req0_valid ||  prio_reg);
    xfer      = grant0 || grant1;
    prio_next = prio_reg;
    if (grant0)
      prio_next = 1'b1;
    else if (grant1)
      prio_next = 1'b0;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      prio_reg <= prio_next;
      if (xfer) begin
        mul_a <= grant1 ? bus.req1_a : bus.req0_a;
        mul_b <= grant1 ? bus.req1_b : bus.req0_b;
      end
    end
  end

  // Ownership pipeline: entry gi is valid gi cycles after the transfer edge,
  // so the last entry lines up with mul_product for that transfer.
  genvar gi;
  generate
    for (gi = 0; gi <= MUL_LAT; gi++) begin : g_stage
      logic             valid_reg;
      logic             owner_reg;
      logic [TAG_W-1:0] tag_reg;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) begin
            valid_reg <= 1'b0;
            owner_reg <= 1'b0;
            tag_reg   <= '0;
          end else begin
            valid_reg <= xfer;
            owner_reg <= grant1;
            tag_reg   <= grant1 ? bus.req1_tag : bus.req0_tag;
          end
        end
      end else begin : g_shift
        always_ff @(posedge clk) begin
          if (rst) begin
            valid_reg <= 1'b0;
            owner_reg <= 1'b0;
            tag_reg   <= '0;
          end else begin
            valid_reg <= g_stage[gi-1].valid_reg;
            owner_reg <= g_stage[gi-1].owner_reg;
            tag_reg   <= g_stage[gi-1].tag_reg;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      res0_valid_reg <= 1'b0;
      res1_valid_reg <= 1'b0;
      res_data_reg   <= '0;
      res_tag_reg    <= '0;
    end else if (g_stage[MUL_LAT].valid_reg) begin
      res0_valid_reg <= !g_stage[MUL_LAT].owner_reg;
      res1_valid_reg <=  g_stage[MUL_LAT].owner_reg;
      res_data_reg   <= mul_product;
      res_tag_reg    <= g_stage[MUL_LAT].tag_reg;
    end else begin
      res0_valid_reg <= 1'b0;
      res1_valid_reg <= 1'b0;
    end
  end

  assign bus.res0_valid = res0_valid_reg;
  assign bus.res1_valid = res1_valid_reg;
  assign bus.res_data   = res_data_reg;
  assign bus.res_tag    = res_tag_reg;
  assign bus.busy       = (|stage_valid) || res0_valid_reg || res1_valid_reg;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter with a 3-stage multiplier model and an
// issue-order scoreboard checked on every result strobe.
module tb_fpu_mul_arbiter;
  localparam int MUL_LAT = 3;
  localparam int OP_W    = 24;
  localparam int TAG_W   = 4;

  typedef struct {
    logic             port;
    logic [TAG_W-1:0] tag;
    logic [47:0]      prod;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [OP_W-1:0]   mul_a;
  logic [OP_W-1:0]   mul_b;
  logic [2*OP_W-1:0] mul_product;
  logic [47:0] s1, s2, s3;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  fpu_mul_arbiter_if #(.OP_W(OP_W), .TAG_W(TAG_W)) bus ();

  fpu_mul_arbiter #(.MUL_LAT(MUL_LAT), .OP_W(OP_W), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  // Multiplier model: samples operands, product visible MUL_LAT edges later.
  always @(posedge clk) begin
    s1 <= 48'(mul_a) * 48'(mul_b);
    s2 <= s1;
    s3 <= s2;
  end
  assign mul_product = s3;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Record accepted transfers; a reset edge discards everything in flight.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        e.port = 1'b0; e.tag = bus.req0_tag; e.cyc = cyc;
        e.prod = 48'(bus.req0_a) * 48'(bus.req0_b);
        exp_q.push_back(e);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        e.port = 1'b1; e.tag = bus.req1_tag; e.cyc = cyc;
        e.prod = 48'(bus.req1_a) * 48'(bus.req1_b);
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.res0_valid || bus.res1_valid) begin
      chk("strobe_exclusive", 64'(bus.res0_valid & bus.res1_valid), 64'd0);
      chk("strobe_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_port", 64'(bus.res1_valid), 64'(e.port));
        chk("res_tag", 64'(bus.res_tag), 64'(e.tag));
        chk("res_data", 64'(bus.res_data), 64'(e.prod));
        chk("res_latency", 64'(cyc - e.cyc), 64'(MUL_LAT + 1));
      end
      $display("result port=%0d tag=%h data=%h", bus.res1_valid, bus.res_tag, bus.res_data);
    end
  end

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
  endtask

  initial begin
    clear_reqs();
    // Reset with a simultaneous port-0 request: it must be dropped.
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 24'h000123; bus.req0_b = 24'h000001; bus.req0_tag = 4'hF;
    #1;
    chk("reset_ready0", 64'(bus.req0_ready), 64'd1);
    chk("reset_ready1", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    chk("reset_mul_a", 64'(mul_a), 64'd0);
    chk("reset_mul_b", 64'(mul_b), 64'd0);
    chk("reset_res_data", 64'(bus.res_data), 64'd0);
    chk("reset_res_tag", 64'(bus.res_tag), 64'd0);
    chk("reset_res0", 64'(bus.res0_valid), 64'd0);
    chk("reset_res1", 64'(bus.res1_valid), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    clear_reqs();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("dropped_busy", 64'(bus.busy), 64'd0);

    // Single request: 3*5, strobe after edge k+4.
    bus.req0_valid = 1'b1; bus.req0_a = 24'h000003; bus.req0_b = 24'h000005; bus.req0_tag = 4'h2;
    #1;
    chk("single_ready0", 64'(bus.req0_ready), 64'd1);
    $display("issue port=0 a=000003 b=000005 tag=2");
    @(negedge clk);
    clear_reqs();
    chk("single_mul_a", 64'(mul_a), 64'd3);
    chk("single_mul_b", 64'(mul_b), 64'd5);
    chk("single_busy_early", 64'(bus.busy), 64'd1);
    repeat (4) @(negedge clk);
    chk("single_strobe", 64'(bus.res0_valid), 64'd1);
    chk("single_data", 64'(bus.res_data), 64'h00000000000F);
    chk("single_busy_strobe", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("single_strobe_off", 64'(bus.res0_valid), 64'd0);
    chk("single_busy_done", 64'(bus.busy), 64'd0);

    // Contention from reset: grants alternate 0,1,0,1.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1'b1; bus.req0_a = 24'(i + 1); bus.req0_b = 24'h000010; bus.req0_tag = 4'(i);
      bus.req1_valid = 1'b1; bus.req1_a = 24'(32'h1000 + i); bus.req1_b = 24'h000003; bus.req1_tag = 4'(8 + i);
      #1;
      chk("contend_ready0", 64'(bus.req0_ready), 64'((i % 2) == 0));
      chk("contend_ready1", 64'(bus.req1_ready), 64'((i % 2) == 1));
      $display("issue contention step=%0d grant0=%0d grant1=%0d", i, bus.req0_ready, bus.req1_ready);
      @(negedge clk);
    end
    clear_reqs();
    repeat (6) @(negedge clk);

    // Max operands.
    bus.req0_valid = 1'b1; bus.req0_a = 24'hFFFFFF; bus.req0_b = 24'hFFFFFF; bus.req0_tag = 4'h7;
    $display("issue port=0 a=ffffff b=ffffff tag=7");
    @(negedge clk);
    clear_reqs();
    repeat (4) @(negedge clk);
    chk("max_strobe", 64'(bus.res0_valid), 64'd1);
    chk("max_data", 64'(bus.res_data), 64'hFFFFFE000001);
    repeat (2) @(negedge clk);

    // Lone requester on port 1 while prio=0.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req1_valid = 1'b1; bus.req1_a = 24'(i + 7); bus.req1_b = 24'd100; bus.req1_tag = 4'(i + 4);
      #1;
      chk("lone_ready1", 64'(bus.req1_ready), 64'd1);
      chk("lone_ready0", 64'(bus.req0_ready), 64'd0);
      $display("issue port=1 a=%h tag=%h", bus.req1_a, bus.req1_tag);
      @(negedge clk);
    end
    bus.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("lone_strobe1", 64'(bus.res1_valid), 64'd1);
    repeat (3) @(negedge clk);

    // Reset mid-flight: two issued, reset two cycles later.
    bus.req0_valid = 1'b1; bus.req0_a = 24'h000011; bus.req0_b = 24'h000002; bus.req0_tag = 4'h1;
    @(negedge clk);
    clear_reqs();
    bus.req1_valid = 1'b1; bus.req1_a = 24'h000022; bus.req1_b = 24'h000002; bus.req1_tag = 4'h3;
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_res0", 64'(bus.res0_valid), 64'd0);
    chk("flush_res1", 64'(bus.res1_valid), 64'd0);
    bus.req0_valid = 1'b1; bus.req0_a = 24'h000009; bus.req0_b = 24'h000009; bus.req0_tag = 4'hA;
    bus.req1_valid = 1'b1; bus.req1_a = 24'h000004; bus.req1_b = 24'h000004; bus.req1_tag = 4'hB;
    #1;
    chk("flush_ready0", 64'(bus.req0_ready), 64'd1);
    chk("flush_ready1", 64'(bus.req1_ready), 64'd0);
    $display("issue after flush port=0 tag=a");
    @(negedge clk);
    clear_reqs();

    // Bounded drain.
    for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.busy); i++)
      @(negedge clk);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(bus.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
